// File: rtl/snake_pkg.sv
// Shared constants for the Snake PS/2 input path: one-hot direction codes,
// scan codes (set 2), FSM state types and the reverse-direction helper.
// Build option: ARROW_KEYS_EN adds the extended-key (E0-prefixed) decode state.
package snake_pkg;

    // One-hot direction bus values consumed by the game core
    localparam logic [4:0] DIR_NONE  = 5'b00000;
    localparam logic [4:0] DIR_UP    = 5'b00010;
    localparam logic [4:0] DIR_LEFT  = 5'b00100;
    localparam logic [4:0] DIR_DOWN  = 5'b01000;
    localparam logic [4:0] DIR_RIGHT = 5'b10000;

    // Scan codes: WASD + ESC make codes and prefixes
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Arrow keys (second byte after the E0 prefix)
    localparam logic [7:0] SC_ARR_UP    = 8'h75;
    localparam logic [7:0] SC_ARR_LEFT  = 8'h6B;
    localparam logic [7:0] SC_ARR_DOWN  = 8'h72;
    localparam logic [7:0] SC_ARR_RIGHT = 8'h74;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_SHIFT,
        FR_CHECK
    } frame_state_e;

`ifdef ARROW_KEYS_EN
    typedef enum logic [1:0] {
        DEC_BASE,
        DEC_BREAK,
        DEC_EXT
    } dec_state_e;
`else
    typedef enum logic [1:0] {
        DEC_BASE,
        DEC_BREAK
    } dec_state_e;
`endif

    // Direction that would make the snake reverse into itself
    function automatic logic [4:0] dir_opposite(input logic [4:0] d);
        logic [4:0] r;
        case (d)
            DIR_UP:    r = DIR_DOWN;
            DIR_DOWN:  r = DIR_UP;
            DIR_LEFT:  r = DIR_RIGHT;
            DIR_RIGHT: r = DIR_LEFT;
            default:   r = DIR_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises KB_clk/data into the system clock
// domain, samples data on KB_clk falling edges, assembles 11-bit frames,
// checks start/parity/stop and abandons stalled frames after a timeout.
// The frame check is resolved on the 11th edge and registered, so the
// result pulses during the single CHECK cycle that follows.
module ps2_frame_rx
    import snake_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kb_clk_i,
    input  logic       kb_data_i,
    output logic [7:0] scan_code_o,
    output logic       scan_valid_o,
    output logic       frame_err_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] kb_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   kb_prev_q;
    logic                   kb_s;
    logic                   dat_s;
    logic                   fall;

    frame_state_e state_q, state_d;
    logic [3:0]   bitcnt_q, bitcnt_d;
    logic [8:0]   sh_q, sh_d;       // data[7:0] then parity in [8]
    logic [TW-1:0] to_q, to_d;
    logic [7:0]   code_q, code_d;
    logic         sv_q, sv_d;
    logic         err_q, err_d;

    assign kb_s  = kb_sync_q[SYNC_STAGES-1];
    assign dat_s = dat_sync_q[SYNC_STAGES-1];
    assign fall  = kb_prev_q & ~kb_s;

    // Synchroniser chains and previous-KB_clk register for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            kb_sync_q  <= '0;
            dat_sync_q <= '0;
            kb_prev_q  <= 1'b0;
        end else begin
            kb_sync_q  <= {kb_sync_q[SYNC_STAGES-2:0], kb_clk_i};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], kb_data_i};
            kb_prev_q  <= kb_s;
        end
    end

    // Frame FSM state, shift register, timeout counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FR_IDLE;
            bitcnt_q <= '0;
            sh_q     <= '0;
            to_q     <= '0;
            code_q   <= '0;
            sv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            sh_q     <= sh_d;
            to_q     <= to_d;
            code_q   <= code_d;
            sv_q     <= sv_d;
            err_q    <= err_d;
        end
    end

    // Frame FSM next state: start check, LSB-first shift, stop/parity check, timeout
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        sh_d     = sh_q;
        to_d     = to_q;
        code_d   = code_q;
        sv_d     = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            FR_IDLE: begin
                to_d = '0;
                if (fall) begin
                    if (!dat_s) begin
                        state_d  = FR_SHIFT;
                        bitcnt_d = 4'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FR_SHIFT: begin
                if (fall) begin
                    to_d = '0;
                    if (bitcnt_q == 4'(FRAME_BITS - 1)) begin
                        // dat_s is the stop bit; ^sh_q is odd parity over data+parity
                        state_d = FR_CHECK;
                        if (dat_s && (^sh_q)) begin
                            code_d = sh_q[7:0];
                            sv_d   = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        sh_d     = {dat_s, sh_q[8:1]};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = FR_IDLE;
                    bitcnt_d = '0;
                    to_d     = '0;
                    err_d    = 1'b1;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            FR_CHECK: begin
                // Result pulses this cycle; KB_clk edges are far slower than one clk
                state_d  = FR_IDLE;
                bitcnt_d = '0;
            end
            default: begin
                state_d  = FR_IDLE;
                bitcnt_d = '0;
            end
        endcase
    end

    assign scan_code_o  = code_q;
    assign scan_valid_o = sv_q;
    assign frame_err_o  = err_q;

endmodule

// File: rtl/ps2_direction_rx.sv
// Snake PS/2 input stage: frame receiver plus make/break/extended decode
// and reverse-blocking for the one-hot direction bus.
// Build option: ARROW_KEYS_EN enables E0-prefixed arrow keys.
module ps2_direction_rx
    import snake_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       KB_clk,
    input  logic       data,
    output logic [4:0] direction,
    output logic       dir_valid,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    logic [7:0] code;
    logic       sv;

    ps2_frame_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame (
        .clk         (clk),
        .rst         (rst),
        .kb_clk_i    (KB_clk),
        .kb_data_i   (data),
        .scan_code_o (code),
        .scan_valid_o(sv),
        .frame_err_o (frame_err)
    );

    dec_state_e dec_q, dec_d;
    logic [4:0] dir_q, dir_d;
    logic       dv_q, dv_d;
    logic [4:0] cand;
    logic       cand_vld;

    // Decode state and registered direction outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q <= DEC_BASE;
            dir_q <= DIR_NONE;
            dv_q  <= 1'b0;
        end else begin
            dec_q <= dec_d;
            dir_q <= dir_d;
            dv_q  <= dv_d;
        end
    end

    // Decode FSM: only good bytes advance it; releases are swallowed
    always_comb begin
        dec_d    = dec_q;
        cand     = DIR_NONE;
        cand_vld = 1'b0;
        if (sv) begin
            case (dec_q)
                DEC_BASE: begin
                    case (code)
                        SC_BREAK: dec_d = DEC_BREAK;
`ifdef ARROW_KEYS_EN
                        SC_EXT:   dec_d = DEC_EXT;
`endif
                        SC_W:     begin cand = DIR_UP;    cand_vld = 1'b1; end
                        SC_A:     begin cand = DIR_LEFT;  cand_vld = 1'b1; end
                        SC_S:     begin cand = DIR_DOWN;  cand_vld = 1'b1; end
                        SC_D:     begin cand = DIR_RIGHT; cand_vld = 1'b1; end
                        SC_ESC:   begin cand = DIR_NONE;  cand_vld = 1'b1; end
                        default:  dec_d = DEC_BASE;
                    endcase
                end
                DEC_BREAK: dec_d = DEC_BASE;
`ifdef ARROW_KEYS_EN
                DEC_EXT: begin
                    dec_d = DEC_BASE;
                    case (code)
                        SC_ARR_UP:    begin cand = DIR_UP;    cand_vld = 1'b1; end
                        SC_ARR_LEFT:  begin cand = DIR_LEFT;  cand_vld = 1'b1; end
                        SC_ARR_DOWN:  begin cand = DIR_DOWN;  cand_vld = 1'b1; end
                        SC_ARR_RIGHT: begin cand = DIR_RIGHT; cand_vld = 1'b1; end
                        SC_BREAK:     dec_d = DEC_BREAK;
                        default:      dec_d = DEC_BASE;
                    endcase
                end
`endif
                default: dec_d = DEC_BASE;
            endcase
        end
    end

    // Reverse blocking: stop and moves from standstill always pass, U-turns drop
    always_comb begin
        dv_d  = cand_vld &&
                ((cand == DIR_NONE) || (dir_q == DIR_NONE) || (cand != dir_opposite(dir_q)));
        dir_d = dv_d ? cand : dir_q;
    end

    assign direction  = dir_q;
    assign dir_valid  = dv_q;
    assign scan_code  = code;
    assign scan_valid = sv;

endmodule

// File: tb/tb_ps2_direction_rx.sv
// Scoreboard bench for ps2_direction_rx: stimulus tasks push expected events
// (good byte, frame error, direction update) from a key-level model; a
// negedge monitor pops and compares whenever the DUT pulses an output.
module tb_ps2_direction_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       KB_clk;
    logic       data;
    logic [4:0] direction;
    logic       dir_valid;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    ps2_direction_rx dut (
        .clk       (clk),
        .rst       (rst),
        .KB_clk    (KB_clk),
        .data      (data),
        .direction (direction),
        .dir_valid (dir_valid),
        .scan_code (scan_code),
        .scan_valid(scan_valid),
        .frame_err (frame_err)
    );

    always #10 clk = ~clk;

    localparam int EV_SCAN = 0;
    localparam int EV_ERR  = 1;
    localparam int EV_DIR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] val;
    } ev_t;

    ev_t q[$];
    int  checks   = 0;
    int  failures = 0;

    // ---------------- key-level reference model ----------------
    int         m_mode;      // 0 normal, 1 after release prefix, 2 after E0
    int         m_dir;       // 0 stop, 1 up, 2 left, 3 down, 4 right
    logic [7:0] m_last_good;
    int         base_map[logic [7:0]];
    int         ext_map[logic [7:0]];

    function automatic logic [4:0] idx_to_onehot(input int i);
        logic [4:0] r;
        r = 5'b00000;
        if (i != 0) r[i] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_mode      = 0;
        m_dir       = 0;
        m_last_good = 8'h00;
    endtask

    task automatic model_key(input int cand);
        int diff;
        diff = cand - m_dir;
        if (cand == 0 || m_dir == 0 || (diff != 2 && diff != -2)) begin
            m_dir = cand;
            q.push_back('{EV_DIR, {3'b000, idx_to_onehot(cand)}});
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit ext_en;
`ifdef ARROW_KEYS_EN
        ext_en = 1'b1;
`else
        ext_en = 1'b0;
`endif
        m_last_good = b;
        q.push_back('{EV_SCAN, b});
        if (m_mode == 1) begin
            m_mode = 0;
        end else if (m_mode == 2) begin
            m_mode = 0;
            if (ext_map.exists(b)) model_key(ext_map[b]);
            else if (b == 8'hF0) m_mode = 1;
        end else begin
            if (b == 8'hF0) m_mode = 1;
            else if (b == 8'hE0 && ext_en) m_mode = 2;
            else if (base_map.exists(b)) model_key(base_map[b]);
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_raw(input logic [10:0] bits, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            data = bits[i];
            wait_cyc(half);
            KB_clk = 1'b0;
            wait_cyc(half);
            KB_clk = 1'b1;
        end
        data = 1'b1;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par,
                                               input bit bad_stop);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = (~^b) ^ bad_par;
        f[10]  = ~bad_stop;
        return f;
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int half, input int gap);
        if (bad_par || bad_stop) q.push_back('{EV_ERR, m_last_good});
        else model_byte(b);
        send_raw(frame_bits(b, bad_par, bad_stop), 11, half);
        wait_cyc(gap);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int         cyc = 0;
    int         last_sv_cyc = -10;
    logic [4:0] held_dir = 5'b00000;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            held_dir = 5'b00000;
        end else begin
            if (scan_valid) begin
                checks++;
                if (q.size() == 0 || q[0].kind != EV_SCAN) begin
                    failures++;
                    $display("FAIL unexpected_scan_valid code=%h", scan_code);
                end else begin
                    if (scan_code !== q[0].val) begin
                        failures++;
                        $display("FAIL scan_code got=%h exp=%h", scan_code, q[0].val);
                    end
                    void'(q.pop_front());
                end
                last_sv_cyc = cyc;
            end
            if (frame_err) begin
                checks++;
                if (q.size() == 0 || q[0].kind != EV_ERR) begin
                    failures++;
                    $display("FAIL unexpected_frame_err");
                end else begin
                    if (scan_code !== q[0].val) begin
                        failures++;
                        $display("FAIL scan_code_after_err got=%h exp=%h", scan_code, q[0].val);
                    end
                    void'(q.pop_front());
                end
            end
            if (dir_valid) begin
                checks++;
                if (q.size() == 0 || q[0].kind != EV_DIR) begin
                    failures++;
                    $display("FAIL unexpected_dir_valid dir=%b", direction);
                end else begin
                    if (direction !== q[0].val[4:0] || cyc != last_sv_cyc + 1) begin
                        failures++;
                        $display("FAIL dir_update got=%b exp=%b lat=%0d exp_lat=1",
                                 direction, q[0].val[4:0], cyc - last_sv_cyc);
                    end
                    held_dir = q[0].val[4:0];
                    void'(q.pop_front());
                end
            end else begin
                checks++;
                if (direction !== held_dir) begin
                    failures++;
                    $display("FAIL dir_hold got=%b exp=%b", direction, held_dir);
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    logic [7:0] pool[12] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h76, 8'hF0,
                             8'hE0, 8'h75, 8'h6B, 8'h72, 8'h74, 8'h1D};

    initial begin
        base_map[8'h1D] = 1; base_map[8'h1C] = 2; base_map[8'h1B] = 3;
        base_map[8'h23] = 4; base_map[8'h76] = 0;
        ext_map[8'h75] = 1; ext_map[8'h6B] = 2; ext_map[8'h72] = 3; ext_map[8'h74] = 4;
        model_reset();

        rst = 1'b1; KB_clk = 1'b1; data = 1'b1;
        wait_cyc(5);
        chk("reset_direction", {3'b000, direction}, 8'h00);
        chk("reset_scan_code", scan_code, 8'h00);
        chk("reset_pulses", {5'b0, dir_valid, scan_valid, frame_err}, 8'h00);
        rst = 1'b0;
        wait_cyc(5);

        send_frame(8'h1D, 0, 0, 40, 10);
        chk("dir_up", {3'b000, direction}, 8'b00010);
        send_frame(8'h1B, 0, 0, 40, 10);
        chk("reverse_blocked", {3'b000, direction}, 8'b00010);
        send_frame(8'h23, 0, 0, 40, 10);
        chk("dir_right", {3'b000, direction}, 8'b10000);
        send_frame(8'h1C, 1, 0, 30, 10);
        chk("bad_parity_dir", {3'b000, direction}, 8'b10000);
        chk("bad_parity_code", scan_code, 8'h23);

        // six bits then silence: timeout abandons the partial frame
        q.push_back('{EV_ERR, m_last_good});
        send_raw(frame_bits(8'h1C, 0, 0), 6, 20);
        wait_cyc(5200);
        chk("timeout_seen", 8'(q.size()), 8'd0);
        send_frame(8'h76, 0, 0, 20, 10);
        chk("dir_stop", {3'b000, direction}, 8'b00000);

        send_frame(8'hF0, 0, 0, 20, 0);
        send_frame(8'h1D, 0, 0, 20, 0);
        send_frame(8'h1C, 0, 0, 20, 10);
        chk("release_then_left", {3'b000, direction}, 8'b00100);

        send_frame(8'hE0, 0, 0, 20, 0);
        send_frame(8'h74, 0, 0, 20, 10);
`ifdef ARROW_KEYS_EN
        chk("ext_right", {3'b000, direction}, 8'b10000);
`else
        chk("ext_ignored", {3'b000, direction}, 8'b00100);
`endif
        send_frame(8'hE0, 0, 0, 20, 0);
        send_frame(8'hF0, 0, 0, 20, 0);
        send_frame(8'h74, 0, 0, 20, 10);
        send_frame(8'h1D, 0, 1, 20, 10);   // bad stop bit
`ifdef ARROW_KEYS_EN
        chk("ext_release", {3'b000, direction}, 8'b10000);
`else
        chk("ext_release", {3'b000, direction}, 8'b00100);
`endif

        // bad start bit: one edge with data high
        q.push_back('{EV_ERR, m_last_good});
        send_raw(11'h7FF, 1, 20);
        wait_cyc(10);

        // reset in the middle of a frame
        send_raw(frame_bits(8'h23, 0, 0), 5, 20);
        data = 1'b0; wait_cyc(20); KB_clk = 1'b0; wait_cyc(5);
        rst = 1'b1;
        wait_cyc(3);
        chk("midreset_dir", {3'b000, direction}, 8'h00);
        chk("midreset_code", scan_code, 8'h00);
        chk("midreset_pulses", {5'b0, dir_valid, scan_valid, frame_err}, 8'h00);
        KB_clk = 1'b1; data = 1'b1;
        model_reset();
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(5);
        send_frame(8'h23, 0, 0, 20, 10);
        chk("after_reset_right", {3'b000, direction}, 8'b10000);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            logic [7:0] b;
            int         r;
            r = int'($urandom_range(0, 99));
            b = (r < 75) ? pool[$urandom_range(0, 11)] : 8'($urandom);
            r = int'($urandom_range(0, 99));
            send_frame(b, r < 10, r >= 95, int'($urandom_range(8, 30)),
                       int'($urandom_range(0, 40)));
        end

        for (int i = 0; i < 200 && q.size() != 0; i++) wait_cyc(1);
        chk("queue_drained", 8'(q.size()), 8'd0);
        chk("final_dir", {3'b000, direction}, {3'b000, idx_to_onehot(m_dir)});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_direction_rx.md
Name: ps2_direction_rx

Overview:
- Upstream input stage for the Snake game. Receives PS/2 keyboard frames on the system clock domain, checks each frame, and decodes make/break/extended sequences.
- Drives the one-hot `direction` bus that the game core consumes on its update tick.
- Replaces free-running negedge-KB_clk capture with synchronised, error-checked, timeout-protected reception.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on KB_clk and data (min 2).
- TIMEOUT_CYCLES, 5000: clk cycles without a KB_clk falling edge before a partial frame is abandoned (100 us at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active-high.
- KB_clk  in  1  PS/2 clock, asynchronous.
- data  in  1  PS/2 data, asynchronous.
- direction  out  5  one-hot: 00000 stop/centre, 00010 up, 00100 left, 01000 down, 10000 right.
- dir_valid  out  1  1-cycle pulse when direction is (re)written.
- scan_code  out  8  last good frame byte.
- scan_valid  out  1  1-cycle pulse per good frame.
- frame_err  out  1  1-cycle pulse on bad start, stop or parity, or on timeout.

Behaviour:
- Reset: all outputs 0. Both FSMs go to idle/BASE. Synchronisers, bit counter and timeout counter clear. rst wins over every simultaneous event, including mid-frame.
- Synchronisation: KB_clk and data each pass through SYNC_STAGES flip-flops. A falling edge is detected when the previous synchronised KB_clk is 1 and the current one is 0. data is sampled in that same cycle.
- Frame FSM, IDLE:
  - On a falling edge, sample the start bit.
  - If the start bit is 0, go to SHIFT with bit count 1.
  - If it is 1, pulse frame_err and stay in IDLE.
- Frame FSM, SHIFT:
  - Each falling edge shifts in the next bit, LSB first: 8 data bits, then odd parity, then stop. 11 bits in total.
  - The timeout counter reloads on every edge. If it reaches TIMEOUT_CYCLES, pulse frame_err and go to IDLE.
- Frame FSM, CHECK (one cycle, entered after the 11th edge):
  - Good frame requires stop = 1 and an odd count of ones across data + parity.
  - Good frame: scan_code <= byte, scan_valid = 1.
  - Bad frame: frame_err = 1 and scan_code is unchanged.
  - Then go to IDLE.
- Latency: the 11th edge is detected in cycle N; scan_valid is high in cycle N+1; direction and dir_valid update in cycle N+2.
- Decode FSM (advances only on scan_valid):
  - In BASE:
    - 0xF0 goes to BREAK.
    - 0xE0 goes to EXT (only when the feature is enabled).
    - Make codes: 0x1D up, 0x1C left, 0x1B down, 0x23 right, 0x76 stop.
    - Any other byte is ignored and the FSM stays in BASE.
  - In BREAK: the next byte is consumed without effect and the FSM returns to BASE. Releases never change direction.
- Direction acceptance:
  - A decoded direction that is the exact opposite of the current direction is dropped, with no dir_valid.
  - stop is always accepted. Any direction is accepted from 00000.
  - Repeating the same direction (typematic) pulses dir_valid with the value unchanged.
- Outputs are registered. Back-to-back frames with no idle gap are supported. A frame error does not change the decode FSM state.

Optional Feature:
- Macro ARROW_KEYS_EN.
- Defined:
  - BASE + 0xE0 goes to EXT.
  - EXT + 0x75 up, 0x6B left, 0x72 down, 0x74 right, each followed by a return to BASE.
  - EXT + 0xF0 goes to BREAK.
  - Any other byte in EXT returns to BASE.
- Undefined: 0xE0 is an ignored byte, the EXT state does not exist, and arrow keys have no effect.

Decomposition:
- Package snake_pkg holds:
  - DIR_NONE/UP/LEFT/DOWN/RIGHT (5-bit);
  - scan constants SC_W/A/S/D/ESC/BREAK/EXT and the arrow codes;
  - the decode-state enum.
- Sub-module ps2_frame_rx contains the synchroniser, edge detector, shift register, parity/stop check and timeout. It outputs scan_code, scan_valid and frame_err.
- The top level holds the decode FSM and the reverse-blocking logic.

Test Plan:
- Send 0x1D (parity 1, stop 1) with 40 us half-period. Expect scan_valid with 0x1D, then direction = 00010 and dir_valid one cycle later.
- From direction 00010, send 0x1B. Expect no dir_valid and direction stays 00010. Then send 0x23: direction = 10000.
- Send 0x1C with wrong parity. Expect frame_err pulse, no scan_valid, and direction unchanged.
- Send 6 bits, then hold KB_clk high for 5000 cycles. Expect frame_err; a following good frame 0x76 gives direction = 00000.
- Sequence F0 1D then 1C. Only 1C sets direction (00100). With ARROW_KEYS_EN, E0 74 gives 10000 and E0 F0 74 changes nothing.
- Assert rst on bit 5 of a frame. Expect all outputs 0; a following full frame 0x23 decodes correctly.
